// File: rtl/mem_access_stage.sv
// MIPS MEM pipeline stage: sized loads/stores over a req/ack data-memory port with timeout,
// upstream stall, BEQ/BNE resolution and registered MEM/WB outputs.
module mem_access_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic [DATA_W-1:0]   ex_alu_result,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic [DATA_W-1:0]   ex_branch_addr,
    input  logic                ex_zero,
    input  logic [REG_W-1:0]    ex_regdest,
    input  logic                ex_reg_write,
    input  logic                ex_branch,
    input  logic                ex_branch_ne,
    input  logic                ex_mem_read,
    input  logic                ex_mem_write,
    input  logic [1:0]          ex_size,
    input  logic                ex_unsigned,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                stall,
    output logic                pcsrc,
    output logic [DATA_W-1:0]   pcsrc_addr,
    output logic                wb_valid,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [DATA_W-1:0]   wb_read_data,
    output logic [DATA_W-1:0]   wb_alu_result,
    output logic [REG_W-1:0]    wb_regdest,
    output logic                misalign_exc,
    output logic                bus_err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                unsigned_q, unsigned_d;
    logic                read_q, read_d;
    logic                reg_write_q, reg_write_d;
    logic [REG_W-1:0]    regdest_q, regdest_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic                wb_valid_q, wb_valid_d;
    logic                wb_reg_write_q, wb_reg_write_d;
    logic                wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [DATA_W-1:0]   wb_read_data_q, wb_read_data_d;
    logic [DATA_W-1:0]   wb_alu_result_q, wb_alu_result_d;
    logic [REG_W-1:0]    wb_regdest_q, wb_regdest_d;
    logic                misalign_q, misalign_d;
    logic                bus_err_q, bus_err_d;

    logic [OFF_W-1:0]    off;
    logic                is_mem;
    logic                misaligned;
    logic                timeout;
    logic [BE_W-1:0]     be_new;
    logic [DATA_W-1:0]   wdata_sh;
    logic [DATA_W-1:0]   rdata_sh;
    logic [DATA_W-1:0]   load_ext;

    assign off      = ex_alu_result[OFF_W-1:0];
    assign is_mem   = ex_mem_read | ex_mem_write;
    assign wdata_sh = ex_wdata << {off, 3'b000};
    assign rdata_sh = mem_rdata >> {off_q, 3'b000};
    assign timeout  = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        misaligned = 1'b0;
        be_new     = '0;
        case (ex_size)
            2'b00: begin
                be_new = BE_W'(1) << off;
            end
            2'b01: begin
                misaligned = off[0];
                be_new     = BE_W'(3) << off;
            end
            2'b10: begin
                misaligned = |off[1:0];
                be_new     = BE_W'(4'hF) << off;
            end
            default: begin
                // Dword only exists on the 64-bit datapath.
                misaligned = (DATA_W == 32) ? 1'b1 : |off;
                be_new     = '1;
            end
        endcase
    end

    always_comb begin
        load_ext = rdata_sh;
        case (size_q)
            2'b00: load_ext = unsigned_q ? DATA_W'(rdata_sh[7:0])
                                         : DATA_W'($signed(rdata_sh[7:0]));
            2'b01: load_ext = unsigned_q ? DATA_W'(rdata_sh[15:0])
                                         : DATA_W'($signed(rdata_sh[15:0]));
            2'b10: load_ext = unsigned_q ? DATA_W'(rdata_sh[31:0])
                                         : DATA_W'($signed(rdata_sh[31:0]));
            default: load_ext = rdata_sh;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_be_d        = mem_be_q;
        off_d           = off_q;
        size_d          = size_q;
        unsigned_d      = unsigned_q;
        read_d          = read_q;
        reg_write_d     = reg_write_q;
        regdest_d       = regdest_q;
        alu_d           = alu_q;
        wb_valid_d      = wb_valid_q;
        wb_reg_write_d  = wb_reg_write_q;
        wb_mem_to_reg_d = wb_mem_to_reg_q;
        wb_read_data_d  = wb_read_data_q;
        wb_alu_result_d = wb_alu_result_q;
        wb_regdest_d    = wb_regdest_q;
        misalign_d      = 1'b0;
        bus_err_d       = 1'b0;
        stall           = 1'b0;

        case (state_q)
            StIdle: begin
                if (ex_valid && is_mem && misaligned) begin
                    misalign_d     = 1'b1;
                    wb_valid_d     = 1'b0;
                    wb_reg_write_d = 1'b0;
                end else if (ex_valid && is_mem) begin
                    stall       = 1'b1;
                    state_d     = StAccess;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ex_mem_write;
                    mem_addr_d  = {ex_alu_result[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_wdata_d = wdata_sh;
                    mem_be_d    = be_new;
                    off_d       = off;
                    size_d      = ex_size;
                    unsigned_d  = ex_unsigned;
                    read_d      = ex_mem_read;
                    reg_write_d = ex_reg_write;
                    regdest_d   = ex_regdest;
                    alu_d       = ex_alu_result;
                    wb_valid_d  = 1'b0;
                end else begin
                    wb_valid_d      = ex_valid;
                    wb_reg_write_d  = ex_reg_write;
                    wb_mem_to_reg_d = 1'b0;
                    wb_alu_result_d = ex_alu_result;
                    wb_regdest_d    = ex_regdest;
                end
            end
            StAccess: begin
                stall = ~mem_ack & ~timeout;
                if (mem_ack || timeout) begin
                    state_d     = StIdle;
                    mem_req_d   = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_be_d    = '0;
                end
                // Ack takes priority over a coincident timeout.
                if (mem_ack) begin
                    wb_valid_d      = 1'b1;
                    wb_reg_write_d  = reg_write_q;
                    wb_mem_to_reg_d = read_q;
                    wb_read_data_d  = load_ext;
                    wb_alu_result_d = alu_q;
                    wb_regdest_d    = regdest_q;
                end else if (timeout) begin
                    bus_err_d      = 1'b1;
                    wb_valid_d     = 1'b0;
                    wb_reg_write_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= StIdle;
            cnt_q           <= '0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_be_q        <= '0;
            off_q           <= '0;
            size_q          <= '0;
            unsigned_q      <= 1'b0;
            read_q          <= 1'b0;
            reg_write_q     <= 1'b0;
            regdest_q       <= '0;
            alu_q           <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_read_data_q  <= '0;
            wb_alu_result_q <= '0;
            wb_regdest_q    <= '0;
            misalign_q      <= 1'b0;
            bus_err_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_be_q        <= mem_be_d;
            off_q           <= off_d;
            size_q          <= size_d;
            unsigned_q      <= unsigned_d;
            read_q          <= read_d;
            reg_write_q     <= reg_write_d;
            regdest_q       <= regdest_d;
            alu_q           <= alu_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_read_data_q  <= wb_read_data_d;
            wb_alu_result_q <= wb_alu_result_d;
            wb_regdest_q    <= wb_regdest_d;
            misalign_q      <= misalign_d;
            bus_err_q       <= bus_err_d;
        end
    end

    assign pcsrc      = (state_q == StIdle) & ex_valid & ex_branch & (ex_zero ^ ex_branch_ne);
    assign pcsrc_addr = ex_branch_addr;

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_be        = mem_be_q;
    assign wb_valid      = wb_valid_q;
    assign wb_reg_write  = wb_reg_write_q;
    assign wb_mem_to_reg = wb_mem_to_reg_q;
    assign wb_read_data  = wb_read_data_q;
    assign wb_alu_result = wb_alu_result_q;
    assign wb_regdest    = wb_regdest_q;
    assign misalign_exc  = misalign_q;
    assign bus_err       = bus_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: 32-bit instance with a short timeout plus a 64-bit instance.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    // 32-bit instance
    logic        ex_valid, ex_zero, ex_reg_write, ex_branch, ex_branch_ne;
    logic        ex_mem_read, ex_mem_write, ex_unsigned;
    logic [31:0] ex_alu_result, ex_wdata, ex_branch_addr;
    logic [4:0]  ex_regdest;
    logic [1:0]  ex_size;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall, pcsrc, wb_valid, wb_reg_write, wb_mem_to_reg, misalign_exc, bus_err;
    logic [31:0] pcsrc_addr, wb_read_data, wb_alu_result;
    logic [4:0]  wb_regdest;

    mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT(4)) u_dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_wdata(ex_wdata),
        .ex_branch_addr(ex_branch_addr), .ex_zero(ex_zero), .ex_regdest(ex_regdest),
        .ex_reg_write(ex_reg_write), .ex_branch(ex_branch), .ex_branch_ne(ex_branch_ne),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .pcsrc(pcsrc), .pcsrc_addr(pcsrc_addr),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_regdest(wb_regdest),
        .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    // 64-bit instance
    logic        b_ex_valid, b_ex_mem_read, b_ex_unsigned, b_mem_ack;
    logic [63:0] b_ex_alu_result, b_mem_rdata;
    logic [1:0]  b_ex_size;
    logic        b_mem_req, b_mem_we, b_stall, b_pcsrc, b_wb_valid, b_wb_reg_write;
    logic        b_wb_mem_to_reg, b_misalign_exc, b_bus_err;
    logic [63:0] b_mem_addr, b_mem_wdata, b_pcsrc_addr, b_wb_read_data, b_wb_alu_result;
    logic [7:0]  b_mem_be;
    logic [4:0]  b_wb_regdest;

    mem_access_stage #(.DATA_W(64), .REG_W(5), .TIMEOUT(16)) u_dut64 (
        .clk(clk), .reset(reset),
        .ex_valid(b_ex_valid), .ex_alu_result(b_ex_alu_result), .ex_wdata(64'd0),
        .ex_branch_addr(64'd0), .ex_zero(1'b0), .ex_regdest(5'd10),
        .ex_reg_write(1'b1), .ex_branch(1'b0), .ex_branch_ne(1'b0),
        .ex_mem_read(b_ex_mem_read), .ex_mem_write(1'b0), .ex_size(b_ex_size),
        .ex_unsigned(b_ex_unsigned),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_rdata(b_mem_rdata),
        .mem_ack(b_mem_ack),
        .stall(b_stall), .pcsrc(b_pcsrc), .pcsrc_addr(b_pcsrc_addr),
        .wb_valid(b_wb_valid), .wb_reg_write(b_wb_reg_write),
        .wb_mem_to_reg(b_wb_mem_to_reg), .wb_read_data(b_wb_read_data),
        .wb_alu_result(b_wb_alu_result), .wb_regdest(b_wb_regdest),
        .misalign_exc(b_misalign_exc), .bus_err(b_bus_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        m2r;
        logic        rw;
    } wb_exp_t;

    wb_exp_t sb[$];
    wb_exp_t mon_e;
    int      total = 0;
    int      bad = 0;
    int      stall_cycles;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] rdata, input logic m2r, input logic rw);
        wb_exp_t e;
        e.rd = rd; e.alu = alu; e.rdata = rdata; e.m2r = m2r; e.rw = rw;
        sb.push_back(e);
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_zero = 0; ex_reg_write = 0; ex_branch = 0; ex_branch_ne = 0;
        ex_mem_read = 0; ex_mem_write = 0; ex_unsigned = 0; ex_alu_result = 0;
        ex_wdata = 0; ex_branch_addr = 0; ex_regdest = 0; ex_size = 0;
    endtask

    task automatic clear_b();
        b_ex_valid = 0; b_ex_mem_read = 0; b_ex_unsigned = 0; b_ex_alu_result = 0;
        b_ex_size = 0;
    endtask

    task automatic drive_mem(input logic rd_op, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd, input logic uns);
        clear_ex();
        ex_valid = 1; ex_mem_read = rd_op; ex_mem_write = ~rd_op; ex_size = size;
        ex_alu_result = addr; ex_wdata = wdata; ex_regdest = rd; ex_reg_write = rd_op;
        ex_unsigned = uns;
    endtask

    task automatic drive_br(input logic ne, input logic zero, input logic [31:0] target);
        clear_ex();
        ex_valid = 1; ex_branch = 1; ex_branch_ne = ne; ex_zero = zero;
        ex_branch_addr = target; ex_alu_result = 32'h1;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every retirement must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && wb_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $error("FAIL sb_unexpected observed=rd%0d expected=none", wb_regdest);
            end else begin
                mon_e = sb.pop_front();
                chk("wb_regdest", 64'(wb_regdest), 64'(mon_e.rd));
                chk("wb_alu_result", 64'(wb_alu_result), 64'(mon_e.alu));
                chk("wb_mem_to_reg", 64'(wb_mem_to_reg), 64'(mon_e.m2r));
                chk("wb_reg_write", 64'(wb_reg_write), 64'(mon_e.rw));
                if (mon_e.m2r) chk("wb_read_data", 64'(wb_read_data), 64'(mon_e.rdata));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; mem_ack = 0; mem_rdata = 0; b_mem_ack = 0; b_mem_rdata = 0;
        clear_ex(); clear_b();
        @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_be", 64'(mem_be), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_exc", 64'({misalign_exc, bus_err}), 64'd0);
        chk("rst_b_mem_req", 64'(b_mem_req), 64'd0);
        next();
        reset = 0;
        next();

        // Back-to-back ALU ops: one cycle each, no bubble
        clear_ex(); ex_valid = 1; ex_alu_result = 32'h1234; ex_regdest = 3; ex_reg_write = 1;
        push_exp(5'd3, 32'h1234, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("alu1_stall", 64'(stall), 64'd0);
        next();
        ex_alu_result = 32'h55AA; ex_regdest = 4;
        push_exp(5'd4, 32'h55AA, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("alu2_stall", 64'(stall), 64'd0);
        next();
        clear_ex();

        // LB signed at 0x103, ack after two waiting ACCESS cycles
        drive_mem(1'b1, 2'b00, 32'h103, 32'h0, 5'd5, 1'b0);
        push_exp(5'd5, 32'h103, 32'hFFFF_FF80, 1'b1, 1'b1);
        stall_cycles = 0;
        @(negedge clk);
        chk("lb_issue_stall", 64'(stall), 64'd1);
        chk("lb_issue_noreq", 64'(mem_req), 64'd0);
        stall_cycles += int'(stall);
        next();
        @(negedge clk);
        chk("lb_req", 64'(mem_req), 64'd1);
        chk("lb_addr", 64'(mem_addr), 64'h100);
        chk("lb_be", 64'(mem_be), 64'b1000);
        chk("lb_we", 64'(mem_we), 64'd0);
        stall_cycles += int'(stall);
        next();
        @(negedge clk);
        stall_cycles += int'(stall);
        next();
        mem_ack = 1; mem_rdata = 32'h8012_3456;
        @(negedge clk);
        chk("lb_ack_stall", 64'(stall), 64'd0);
        stall_cycles += int'(stall);
        next();
        mem_ack = 0; mem_rdata = 0; clear_ex();
        chk("lb_stall_cycles", 64'(stall_cycles), 64'd3);
        @(negedge clk);
        chk("lb_req_drop", 64'(mem_req), 64'd0);
        next();

        // LHU at 0x102, ack in the first ACCESS cycle
        drive_mem(1'b1, 2'b01, 32'h102, 32'h0, 5'd6, 1'b1);
        push_exp(5'd6, 32'h102, 32'h0000_8001, 1'b1, 1'b1);
        next();
        mem_ack = 1; mem_rdata = 32'h8001_1234;
        @(negedge clk);
        chk("lhu_be", 64'(mem_be), 64'b1100);
        next();
        mem_ack = 0; mem_rdata = 0; clear_ex();
        next();

        // SH at 0x102
        drive_mem(1'b0, 2'b01, 32'h102, 32'h0000_BEEF, 5'd0, 1'b0);
        push_exp(5'd0, 32'h102, 32'h0, 1'b0, 1'b0);
        next();
        @(negedge clk);
        chk("sh_addr", 64'(mem_addr), 64'h100);
        chk("sh_be", 64'(mem_be), 64'b1100);
        chk("sh_wdata", 64'(mem_wdata), 64'hBEEF_0000);
        chk("sh_we", 64'(mem_we), 64'd1);
        mem_ack = 1;
        next();
        mem_ack = 0; clear_ex();
        @(negedge clk);
        chk("sh_idle_we", 64'({mem_req, mem_we}), 64'd0);
        next();

        // LW misaligned at 0x101
        drive_mem(1'b1, 2'b10, 32'h101, 32'h0, 5'd7, 1'b0);
        @(negedge clk);
        chk("lw_mis_stall", 64'(stall), 64'd0);
        next();
        clear_ex();
        @(negedge clk);
        chk("lw_mis_exc", 64'(misalign_exc), 64'd1);
        chk("lw_mis_noreq", 64'(mem_req), 64'd0);
        chk("lw_mis_wbv", 64'(wb_valid), 64'd0);
        next();
        @(negedge clk);
        chk("lw_mis_pulse", 64'(misalign_exc), 64'd0);
        next();

        // Dword on the 32-bit datapath is illegal
        drive_mem(1'b1, 2'b11, 32'h100, 32'h0, 5'd7, 1'b0);
        next();
        clear_ex();
        @(negedge clk);
        chk("ld32_exc", 64'(misalign_exc), 64'd1);
        next();

        // Timeout: TIMEOUT=4, no ack ever
        drive_mem(1'b1, 2'b10, 32'h200, 32'h0, 5'd8, 1'b0);
        @(negedge clk);
        chk("to_issue_stall", 64'(stall), 64'd1);
        for (int i = 0; i < 4; i++) begin
            next();
            @(negedge clk);
            chk("to_req_held", 64'(mem_req), 64'd1);
            chk("to_stall", 64'(stall), (i == 3) ? 64'd0 : 64'd1);
        end
        next();
        clear_ex();
        @(negedge clk);
        chk("to_bus_err", 64'(bus_err), 64'd1);
        chk("to_req_drop", 64'(mem_req), 64'd0);
        chk("to_wbv", 64'(wb_valid), 64'd0);
        next();
        @(negedge clk);
        chk("to_pulse", 64'(bus_err), 64'd0);
        next();

        // Reset in ACCESS; late ack must be ignored
        drive_mem(1'b1, 2'b10, 32'h300, 32'h0, 5'd9, 1'b0);
        next();
        @(negedge clk);
        chk("rs_req", 64'(mem_req), 64'd1);
        #1;
        reset = 1;
        clear_ex();
        #1;
        chk("rs_req_async", 64'(mem_req), 64'd0);
        next();
        reset = 0;
        next();
        next();
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rs_ack_stall", 64'(stall), 64'd0);
        chk("rs_ack_req", 64'(mem_req), 64'd0);
        next();
        mem_ack = 0; mem_rdata = 0;
        @(negedge clk);
        chk("rs_ack_wbv", 64'(wb_valid), 64'd0);
        next();

        // Branches
        drive_br(1'b1, 1'b0, 32'h4000);
        push_exp(5'd0, 32'h1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("bne_pcsrc", 64'(pcsrc), 64'd1);
        chk("bne_addr", 64'(pcsrc_addr), 64'h4000);
        next();
        drive_br(1'b0, 1'b0, 32'h5000);
        push_exp(5'd0, 32'h1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("beq_nz_pcsrc", 64'(pcsrc), 64'd0);
        next();
        drive_br(1'b0, 1'b1, 32'h6000);
        push_exp(5'd0, 32'h1, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("beq_z_pcsrc", 64'(pcsrc), 64'd1);
        next();
        clear_ex();
        next();

        // 64-bit LD at 0x8
        b_ex_valid = 1; b_ex_mem_read = 1; b_ex_size = 2'b11; b_ex_alu_result = 64'h8;
        @(negedge clk);
        chk("ld_stall", 64'(b_stall), 64'd1);
        next();
        @(negedge clk);
        chk("ld_be", 64'(b_mem_be), 64'hFF);
        chk("ld_addr", b_mem_addr, 64'h8);
        b_mem_ack = 1; b_mem_rdata = 64'h0123_4567_89AB_CDEF;
        next();
        b_mem_ack = 0; clear_b();
        @(negedge clk);
        chk("ld_wbv", 64'(b_wb_valid), 64'd1);
        chk("ld_data", b_wb_read_data, 64'h0123_4567_89AB_CDEF);
        next();

        // 64-bit LW signed at 0xC (upper word lane)
        b_ex_valid = 1; b_ex_mem_read = 1; b_ex_size = 2'b10; b_ex_alu_result = 64'hC;
        next();
        @(negedge clk);
        chk("lw64_be", 64'(b_mem_be), 64'hF0);
        chk("lw64_addr", b_mem_addr, 64'h8);
        b_mem_ack = 1; b_mem_rdata = 64'h8765_4321_0000_0000;
        next();
        b_mem_ack = 0; clear_b();
        @(negedge clk);
        chk("lw64_data", b_wb_read_data, 64'hFFFF_FFFF_8765_4321);
        next();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
